// File: rtl/conv3x3_window_mac.sv
// 3x3 window multiply-accumulate stage fed by the line buffer taps R0..R8.
// Tracks pixel position, drops edge windows, and emits ReLU-quantized results with a linear address.
module conv3x3_window_mac #(
    parameter int IMG_W  = 58,
    parameter int IMG_H  = 58,
    parameter int DATA_W = 9,
    parameter int W_W    = 8,
    parameter int B_W    = 16,
    parameter int ACC_W  = 22,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [9*W_W-1:0]         weights,
    input  logic signed [B_W-1:0]    bias,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] R0,
    input  logic signed [DATA_W-1:0] R1,
    input  logic signed [DATA_W-1:0] R2,
    input  logic signed [DATA_W-1:0] R3,
    input  logic signed [DATA_W-1:0] R4,
    input  logic signed [DATA_W-1:0] R5,
    input  logic signed [DATA_W-1:0] R6,
    input  logic signed [DATA_W-1:0] R7,
    input  logic signed [DATA_W-1:0] R8,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [11:0]              out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int P_W = DATA_W + W_W;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((1 << (OUT_W - 1)) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic signed [W_W-1:0]    w_q    [9];
    logic signed [B_W-1:0]    b_q;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     pv_d, v2, v3;
    logic [11:0]              out_idx;
    logic signed [DATA_W-1:0] r_tap  [9];
    logic signed [P_W-1:0]    prod_q [9];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  relu_c;
    logic signed [ACC_W-1:0]  sh_c;
    logic [OUT_W-1:0]         q_c;

    assign r_tap[0] = R0;
    assign r_tap[1] = R1;
    assign r_tap[2] = R2;
    assign r_tap[3] = R3;
    assign r_tap[4] = R4;
    assign r_tap[5] = R5;
    assign r_tap[6] = R6;
    assign r_tap[7] = R7;
    assign r_tap[8] = R8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            row   <= '0;
            col   <= '0;
            b_q   <= '0;
            for (int unsigned i = 0; i < 9; i++) w_q[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int unsigned i = 0; i < 9; i++) w_q[i] <= weights[i*W_W +: W_W];
                    b_q   <= bias;
                    row   <= '0;
                    col   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: if (pix_valid) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) state <= DRAIN;
                        else                 row   <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: if (!pv_d && !v2 && !v3) begin
                    // done lands in the cycle after the final out_valid
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sum_c = {{(ACC_W-B_W){b_q[B_W-1]}}, b_q};
        for (int unsigned i = 0; i < 9; i++)
            sum_c = sum_c + {{(ACC_W-P_W){prod_q[i][P_W-1]}}, prod_q[i]};
    end

    always_comb begin
        relu_c = acc_q[ACC_W-1] ? '0 : acc_q;
        sh_c   = relu_c >>> SHIFT;
        q_c    = (sh_c > OMAX) ? OMAX[OUT_W-1:0] : sh_c[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_d      <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_idx   <= '0;
            acc_q     <= '0;
            for (int unsigned i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            // the line buffer shifts on the sampling edge, so taps are consumed a cycle later
            pv_d      <= (state == RUN) && pix_valid && (row >= RW'(2)) && (col >= CW'(2));
            v2        <= pv_d;
            v3        <= v2;
            out_valid <= v3;
            for (int unsigned i = 0; i < 9; i++) prod_q[i] <= r_tap[i] * w_q[i];
            acc_q <= sum_c;
            if (state == IDLE && start) out_idx <= '0;
            else if (v3)                out_idx <= out_idx + 1'b1;
            if (v3) begin
                out_data <= q_c;
                out_addr <= out_idx;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Scoreboard bench for conv3x3_window_mac: models the line buffer taps and the quantized MAC per window.
module tb_conv3x3_window_mac;

    localparam int IMG_W = 58;
    localparam int IMG_H = 58;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
    localparam int SHIFT = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [71:0]       weights = '0;
    logic signed [15:0] bias = '0;
    logic signed [8:0] r_tap [9];
    logic              out_valid;
    logic [8:0]        out_data;
    logic [11:0]       out_addr;
    logic              busy;
    logic              done;

    int pix [NPIX];
    int wn [9];
    int wm [9];
    int bn, bm;
    int exp_addr;
    logic [20:0] sb [$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int out_cnt, done_cnt, first_ov, t_push;

    conv3x3_window_mac #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(9), .W_W(8), .B_W(16),
        .ACC_W(22), .SHIFT(SHIFT), .OUT_W(9)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .weights(weights), .bias(bias),
        .pix_valid(pix_valid),
        .R0(r_tap[0]), .R1(r_tap[1]), .R2(r_tap[2]), .R3(r_tap[3]), .R4(r_tap[4]),
        .R5(r_tap[5]), .R6(r_tap[6]), .R7(r_tap[7]), .R8(r_tap[8]),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tap(input int k, input int i, input int j);
        int idx;
        idx = k - (2 - i) * IMG_W - (2 - j);
        return (idx >= 0) ? pix[idx] : 0;
    endfunction

    function automatic int model(input int k);
        int s;
        s = bm;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += tap(k, i, j) * wm[i*3+j];
        if (s < 0) s = 0;
        s = s >>> SHIFT;
        if (s > 255) s = 255;
        return s;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            out_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                check("out_data", int'(out_data), int'(e[8:0]));
                check("out_addr", int'(out_addr), int'(e[20:9]));
            end
        end
        if (done) begin
            done_cnt++;
            check("done_with_valid", int'(out_valid), 0);
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic start_frame();
        for (int i = 0; i < 9; i++) begin
            weights[i*8 +: 8] = 8'(wn[i]);
            wm[i] = wn[i];
        end
        bias = 16'(bn);
        bm = bn;
        exp_addr = 0; out_cnt = 0; done_cnt = 0; first_ov = -1; t_push = -1;
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
        check("busy_run", int'(busy), 1);
    endtask

    task automatic push(input int k, input bit inj);
        logic [71:0] saved;
        saved = weights;
        pix_valid = 1'b1;
        if (inj) begin
            start   = 1'b1;
            weights = ~weights;
            bias    = ~bias;
        end
        idle_cycle();
        pix_valid = 1'b0;
        start     = 1'b0;
        weights   = saved;
        bias      = 16'(bm);
        if (k == 2*IMG_W + 2) t_push = cyc - 1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                r_tap[i*3+j] = 9'(tap(k, i, j));
        if ((k / IMG_W) >= 2 && (k % IMG_W) >= 2) begin
            sb.push_back({12'(exp_addr), 9'(model(k))});
            exp_addr++;
        end
    endtask

    task automatic run_frame(input bit gaps, input int inj_at, input int abort_at);
        start_frame();
        for (int k = 0; k < NPIX; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) idle_cycle();
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_valid", int'(out_valid), 0);
                check("abort_data", int'(out_data), 0);
                check("abort_addr", int'(out_addr), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_done", int'(done), 0);
                repeat (2) idle_cycle();
                rst = 1'b0;
                sb.delete();
                repeat (10) idle_cycle();
                check("abort_no_done", done_cnt, 0);
                check("abort_idle", int'(busy), 0);
                return;
            end
            push(k, k == inj_at);
        end
        for (int i = 0; i < 40 && done_cnt == 0; i++) idle_cycle();
        check("done_seen", done_cnt, 1);
        check("out_count", out_cnt, NOUT);
        check("sb_left", sb.size(), 0);
        idle_cycle();
        check("busy_after", int'(busy), 0);
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic set_w(input int v, input int b);
        for (int i = 0; i < 9; i++) wn[i] = v;
        bn = b;
    endtask

    task automatic rand_image_weights();
        for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(0, 511)) - 256;
        for (int i = 0; i < 9; i++) wn[i] = int'($urandom_range(0, 255)) - 128;
        bn = int'($urandom_range(0, 4095)) - 2048;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) r_tap[i] = '0;
        repeat (3) idle_cycle();
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_addr", int'(out_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        idle_cycle();

        for (int k = 0; k < NPIX; k++) pix[k] = 10;
        set_w(1, 0);
        run_frame(1'b0, -1, -1);

        for (int k = 0; k < NPIX; k++) pix[k] = k % IMG_W;
        set_w(0, 0);
        wn[2] = 1;
        run_frame(1'b0, -1, -1);
        check("latency", first_ov - t_push, 4);

        for (int k = 0; k < NPIX; k++) pix[k] = 255;
        set_w(127, 0);
        run_frame(1'b0, -1, -1);
        set_w(-1, 0);
        run_frame(1'b0, -1, -1);

        rand_image_weights();
        run_frame(1'b1, 1000, -1);

        rand_image_weights();
        run_frame(1'b0, -1, 2000);
        rand_image_weights();
        run_frame(1'b0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_mac.md
Name: conv3x3_window_mac

Overview:
Downstream consumer of the 3x3 line-buffer window (R0..R8). It tracks the row/column position of every pixel pushed into the line buffer and discards windows that straddle a row boundary or lack two full rows above. Each valid window goes through a 3-stage multiply / adder-tree / ReLU-quantize pipeline. Results are emitted with a linear output-SRAM write address, one output per valid window, for the padded-image convolution layer.

Parameters:
IMG_W, 58, padded image width (must match line buffer img_w)
IMG_H, 58, padded image height
DATA_W, 9, signed pixel width of R0..R8
W_W, 8, signed weight width
B_W, 16, signed bias width
ACC_W, 22, signed accumulator width (17-bit products, 9-term sum, bias)
SHIFT, 0, arithmetic right shift applied after ReLU (truncating)
OUT_W, 9, output width; output is clamped to [0, 2^(OUT_W-1)-1]

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE; latches weights and bias and clears counters
weights  in  9*W_W  w0..w8 packed, w0 at LSBs; wi multiplies Ri
bias  in  B_W  signed bias added to each window sum
pix_valid  in  1  high in the same cycle a pixel Y is presented to the line buffer
R0..R8  in  DATA_W each  signed window taps from the line buffer (R8 = newest pixel)
out_valid  out  1  output result/address valid this cycle
out_data  out  OUT_W  quantized result
out_addr  out  12  linear output index = (row-2)*(IMG_W-2)+(col-2)
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on completion of a frame

Behaviour:
- Reset: state=IDLE; out_valid=0, out_data=0, out_addr=0, busy=0, done=0; all counters, pipeline valids and latched weights/bias cleared. Reset mid-frame aborts the frame with no done pulse; the next start begins a fresh frame.
- FSM:
  - IDLE -> RUN on start; latches weights/bias; row=col=0; out index=0.
  - RUN: each pix_valid advances col (wraps at IMG_W-1 to 0 with row+1). After the IMG_W*IMG_H-th pixel -> DRAIN.
  - DRAIN: waits until all pipeline valid bits are 0 (at most 3 cycles) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start is ignored outside IDLE. pix_valid is ignored in IDLE, DRAIN and DONE.
- Window alignment: the line buffer updates on the edge that samples Y, so R0..R8 are consumed one cycle after pix_valid (register pv_d plus a tag).
- Window validity: the tag is valid iff row>=2 and col>=2 of the pixel just pushed. First valid window is pixel index 2*IMG_W+2 = 118. Windows with col<2 are suppressed (row-wrap garbage).
- Pipeline (edges counted from the edge ending the pix_valid cycle):
  - E1: tag register.
  - E2: nine signed products Ri*wi (DATA_W+W_W bits), registered.
  - E3: sign-extended sum of the products plus bias into ACC_W, registered.
  - E4: ReLU (negative -> 0), >>>SHIFT, clamp to 2^(OUT_W-1)-1; out_data/out_addr registered; out_valid=1.
  - Latency: out_valid is high in cycle t+4 for pix_valid at cycle t. Fully pipelined, one result per cycle.
- out_addr comes from a counter incremented per valid result; 0..(IMG_W-2)*(IMG_H-2)-1 = 0..3135. The counter does not wrap within a frame.
- Gaps in pix_valid are legal at any cycle. They do not alter results, addresses or the result count, only timing. When no result is produced, out_valid=0 and out_data/out_addr hold their last values.
- done is asserted only after the last out_valid, never in the same cycle.

Test Plan:
- Constant image 10, all weights 1, bias 0, SHIFT 0 -> exactly 3136 out_valid pulses, each out_data=90, out_addr 0..3135 in order, then one done pulse, busy low afterwards.
- Ramp image (pixel = col), weights w2=1 others 0 -> out_data at out_addr a equals (a mod 56)+2. First out_valid occurs 4 cycles after the 119th pix_valid.
- Pixels 255, weights 127, bias 0 -> sum 291465 is clamped to out_data=255. Weights -1, bias 0 -> out_data=0 (ReLU).
- Pseudo-random 1-3 cycle pix_valid gaps, random image and weights -> output stream and addresses bit-identical to the gapless golden-model run; count=3136.
- Assert rst in the middle of RUN -> all outputs 0 the same cycle, no done. A new start plus a full frame produces a correct result.
- start pulsed during RUN with different weights -> ignored; results use the originally latched weights.
